tile_rom_mp: RTL and testbench

- Multi-port, parametrised tile-bitmap ROM for the board renderers. It is the successor to the fixed two-port ship bitmap ROM.
- N_CH independent read channels serve the host and guest boards plus overlays. Each channel has tile-index/row addressing, a valid handshake and selectable 1- or 2-stage read latency.
- Bitmaps are generated from TILE_W/TILE_H rules rather than fixed hex. An out-of-range error flag is provided per channel.
- An optional frame-driven blink animates the "hit" tile.

---
 rtl/tile_rom_mp.sv | 163 ++++++++++++++++
 tb/tb_tile_rom_mp.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_rom_mp.sv
// Multi-port tile-bitmap ROM: N_CH independent read channels with 1- or 2-cycle latency.
// Define TILE_ROM_BLINK_EN to make the hit tile (2) invert every BLINK_DIV frame ticks.
module tile_rom_mp #(
  parameter int N_CH      = 2,
  parameter int TILE_W    = 32,
  parameter int TILE_H    = 16,
  parameter int N_TILES   = 4,
  parameter int LATENCY   = 2,
  parameter int BLINK_DIV = 30,
  localparam int TW = $clog2(N_TILES + 1),
  localparam int RW = $clog2(TILE_H)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          rd_en,
  input  logic [N_CH*TW-1:0]       tile_idx,
  input  logic [N_CH*RW-1:0]       row,
  input  logic                     frame_tick,
  output logic [N_CH*TILE_W-1:0]   line_out,
  output logic [N_CH-1:0]          line_valid,
  output logic [N_CH-1:0]          addr_err
);

  // Handshake: rd_en is a single-cycle request with no backpressure. Every
  // request sampled high produces exactly one line_valid pulse LATENCY cycles
  // later, in order; addr_err and line_out are meaningful only with that pulse.

  function automatic logic [TILE_W-1:0] hit_row(input int r);
    logic [TILE_W-1:0] v;
    int d;
    v = '0;
    d = (r * TILE_W) / TILE_H;
    if (d > TILE_W - 2) d = TILE_W - 2;
    for (int c = 0; c < TILE_W; c++) begin
      if (r == 0 || r == TILE_H - 1 || c < 4 || c >= TILE_W - 4 ||
          c == d || c == d + 1 || c == TILE_W - 2 - d || c == TILE_W - 1 - d)
        v[TILE_W-1-c] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [TILE_W-1:0] miss_row(input int r);
    logic [TILE_W-1:0] v;
    v = '0;
    for (int c = 0; c < TILE_W; c++) begin
      if (r == 2 || r == TILE_H - 3) begin
        if (c >= 5 && c <= TILE_W - 6) v[TILE_W-1-c] = 1'b1;
      end else if (r > 2 && r < TILE_H - 3) begin
        if ((c >= 5 && c <= 7) || (c >= TILE_W - 8 && c <= TILE_W - 6))
          v[TILE_W-1-c] = 1'b1;
      end
    end
    return v;
  endfunction

  // Row tables are constant per row index; the row input always wraps into them.
  logic [TILE_W-1:0] hit_rom  [2**RW];
  logic [TILE_W-1:0] miss_rom [2**RW];

  for (genvar g = 0; g < 2**RW; g++) begin : g_rom
    assign hit_rom[g]  = hit_row(g % TILE_H);
    assign miss_rom[g] = miss_row(g % TILE_H);
  end

  logic blink_phase;

`ifdef TILE_ROM_BLINK_EN
  localparam int CW = ($clog2(BLINK_DIV) > 8) ? $clog2(BLINK_DIV) : 8;
  logic [CW-1:0] blink_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == CW'(BLINK_DIV - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end
`else
  localparam int unused_blink_div = BLINK_DIV;
  logic unused_frame_tick;
  assign unused_frame_tick = frame_tick;
  assign blink_phase       = 1'b0;
`endif

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic              src_v;
    logic [TW-1:0]     src_t;
    logic [RW-1:0]     src_r;
    logic [TILE_W-1:0] src_line;
    logic              src_err;
    logic [TILE_W-1:0] out_q;
    logic              valid_q;
    logic              err_q;

    if (LATENCY == 1) begin : g_lat1
      assign src_v = rd_en[k];
      assign src_t = tile_idx[k*TW +: TW];
      assign src_r = row[k*RW +: RW];
    end else begin : g_lat2
      logic          a_v;
      logic [TW-1:0] a_t;
      logic [RW-1:0] a_r;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_v <= 1'b0;
          a_t <= '0;
          a_r <= '0;
        end else begin
          a_v <= rd_en[k];
          if (rd_en[k]) begin
            a_t <= tile_idx[k*TW +: TW];
            a_r <= row[k*RW +: RW];
          end
        end
      end

      assign src_v = a_v;
      assign src_t = a_t;
      assign src_r = a_r;
    end

    always_comb begin
      src_line = '0;
      src_err  = 1'b0;
      if (src_t >= TW'(N_TILES)) begin
        src_err = 1'b1;
      end else if (src_t == TW'(1)) begin
        src_line = '1;
      end else if (src_t == TW'(2)) begin
        src_line = hit_rom[src_r] ^ {TILE_W{blink_phase}};
      end else if (src_t == TW'(3)) begin
        src_line = miss_rom[src_r];
      end
    end

    // Output register holds the last line between valid pulses.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_q   <= '0;
        valid_q <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        valid_q <= src_v;
        if (src_v) begin
          out_q <= src_line;
          err_q <= src_err;
        end
      end
    end

    assign line_out[k*TILE_W +: TILE_W] = out_q;
    assign line_valid[k]                = valid_q;
    assign addr_err[k]                  = err_q;
  end

endmodule

// File: tb/tb_tile_rom_mp.sv
// Bench for tile_rom_mp: a 2-channel LATENCY=2 instance and a 1-channel LATENCY=1
// instance, both BLINK_DIV=2, checked against a scoreboard of expected lines.
module tb_tile_rom_mp;
  localparam int N_CH = 2;
  localparam int W    = 32;
  localparam int H    = 16;
  localparam int NT   = 4;
  localparam int TW   = 3;
  localparam int RW   = 4;
  localparam int BLK  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N_CH-1:0]   rd_en = '0;
  logic [N_CH*TW-1:0] tile_idx = '0;
  logic [N_CH*RW-1:0] row = '0;
  logic              frame_tick = 1'b0;
  logic [N_CH*W-1:0] line_out;
  logic [N_CH-1:0]   line_valid;
  logic [N_CH-1:0]   addr_err;

  logic [0:0]        d1_rd_en = '0;
  logic [TW-1:0]     d1_tile = '0;
  logic [RW-1:0]     d1_row = '0;
  logic [W-1:0]      d1_line;
  logic [0:0]        d1_valid;
  logic [0:0]        d1_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [W:0] exp_q0[$];
  logic [W:0] exp_q1[$];
  logic [W:0] exp_q2[$];
  int cyc_q0[$];
  int cyc_q1[$];
  int cyc_q2[$];
  int tick_cnt = 0;
  logic tb_phase = 1'b0;
  logic [W-1:0] last0 = '0;
  logic [W-1:0] last1 = '0;
  logic [W-1:0] last2 = '0;
  logic [W:0] e;
  int ec;

  tile_rom_mp #(.N_CH(N_CH), .TILE_W(W), .TILE_H(H), .N_TILES(NT), .LATENCY(2), .BLINK_DIV(BLK)) u_dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .tile_idx(tile_idx), .row(row),
    .frame_tick(frame_tick), .line_out(line_out), .line_valid(line_valid), .addr_err(addr_err)
  );

  tile_rom_mp #(.N_CH(1), .TILE_W(W), .TILE_H(H), .N_TILES(NT), .LATENCY(1), .BLINK_DIV(BLK)) u_dut1 (
    .clk(clk), .rst(rst), .rd_en(d1_rd_en), .tile_idx(d1_tile), .row(d1_row),
    .frame_tick(frame_tick), .line_out(d1_line), .line_valid(d1_valid), .addr_err(d1_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Mask with columns a..b set (column 0 is the MSB).
  function automatic logic [W-1:0] cols(input int a, input int b);
    logic [63:0] m;
    m = ((64'd1 << (b - a + 1)) - 64'd1) << (W - 1 - b);
    return m[W-1:0];
  endfunction

  function automatic logic [W:0] model(input int t, input int r);
    logic [W-1:0] v;
    int d;
    v = '0;
    if (t >= NT) return {1'b1, {W{1'b0}}};
    if (t == 1) v = '1;
    if (t == 2) begin
      d = (r * W) / H;
      if (d > W - 2) d = W - 2;
      if (r == 0 || r == H - 1) v = '1;
      else v = cols(0, 3) | cols(W - 4, W - 1) | cols(d, d + 1) | cols(W - 2 - d, W - 1 - d);
      if (tb_phase) v = ~v;
    end
    if (t == 3) begin
      if (r == 2 || r == H - 3) v = cols(5, W - 6);
      else if (r > 2 && r < H - 3) v = cols(5, 7) | cols(W - 8, W - 6);
    end
    return {1'b0, v};
  endfunction

  task automatic drive(input logic [1:0] en, input int t0, input int r0, input int t1, input int r1,
                       input logic e2, input int t2, input int r2);
    rd_en    = en;
    tile_idx = {TW'(t1), TW'(t0)};
    row      = {RW'(r1), RW'(r0)};
    d1_rd_en = e2;
    d1_tile  = TW'(t2);
    d1_row   = RW'(r2);
    if (en[0]) begin exp_q0.push_back(model(t0, r0)); cyc_q0.push_back(cyc + 2); end
    if (en[1]) begin exp_q1.push_back(model(t1, r1)); cyc_q1.push_back(cyc + 2); end
    if (e2)    begin exp_q2.push_back(model(t2, r2)); cyc_q2.push_back(cyc + 1); end
    @(posedge clk); #1;
    rd_en    = '0;
    d1_rd_en = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic tick_frame();
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
`ifdef TILE_ROM_BLINK_EN
    if (tick_cnt == BLK - 1) begin
      tick_cnt = 0;
      tb_phase = ~tb_phase;
    end else begin
      tick_cnt++;
    end
`endif
  endtask

  always @(negedge clk) begin
    if (rst) begin
      last0 = '0;
      last1 = '0;
      last2 = '0;
    end else begin
      if (line_valid[0]) begin
        if (exp_q0.size() == 0) check("ch0_unexpected_valid", 1, 0);
        else begin
          e = exp_q0.pop_front(); ec = cyc_q0.pop_front();
          check("ch0_line", line_out[W-1:0], e[W-1:0]);
          check("ch0_err", addr_err[0], e[W]);
          check("ch0_latency", cyc, ec);
          last0 = e[W-1:0];
        end
      end else check("ch0_hold", line_out[W-1:0], last0);
      if (line_valid[1]) begin
        if (exp_q1.size() == 0) check("ch1_unexpected_valid", 1, 0);
        else begin
          e = exp_q1.pop_front(); ec = cyc_q1.pop_front();
          check("ch1_line", line_out[2*W-1:W], e[W-1:0]);
          check("ch1_err", addr_err[1], e[W]);
          check("ch1_latency", cyc, ec);
          last1 = e[W-1:0];
        end
      end else check("ch1_hold", line_out[2*W-1:W], last1);
      if (d1_valid[0]) begin
        if (exp_q2.size() == 0) check("lat1_unexpected_valid", 1, 0);
        else begin
          e = exp_q2.pop_front(); ec = cyc_q2.pop_front();
          check("lat1_line", d1_line, e[W-1:0]);
          check("lat1_err", d1_err[0], e[W]);
          check("lat1_latency", cyc, ec);
          last2 = e[W-1:0];
        end
      end else check("lat1_hold", d1_line, last2);
    end
  end

  initial begin
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_line", line_out, 64'd0);
    check("rst_valid", line_valid, 64'd0);
    check("rst_err", addr_err, 64'd0);
    check("rst_lat1_line", d1_line, 64'd0);
    check("rst_lat1_valid", {d1_valid, d1_err}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Single miss-tile read, then a full 16-row burst on both channels.
    drive(2'b01, 3, 2, 0, 0, 1'b0, 0, 0);
    idle(4);
    for (int i = 0; i < H; i++) drive(2'b11, 1, i, 3, i, 1'b0, 0, 0);
    idle(4);

    // Out-of-range tile indices alongside in-range reads.
    drive(2'b11, 1, 6, 5, 7, 1'b1, 7, 3);
    drive(2'b11, 4, 0, 2, 9, 1'b1, 0, 0);
    idle(4);

    // Latency-1 instance: ship row then empty row, with idle holds between.
    drive(2'b00, 0, 0, 0, 0, 1'b1, 1, 4);
    idle(2);
    drive(2'b00, 0, 0, 0, 0, 1'b1, 0, 4);
    idle(3);

    // Blink: tile 2 row 0 before and after each pair of frame ticks.
    drive(2'b11, 2, 0, 2, 0, 1'b1, 2, 0);
    idle(3);
    tick_frame(); idle(1); tick_frame(); idle(1);
    drive(2'b11, 2, 0, 2, 0, 1'b1, 2, 0);
    idle(3);
    tick_frame(); idle(1); tick_frame(); idle(1);
    drive(2'b11, 2, 0, 2, 0, 1'b1, 2, 0);
    idle(3);
    tick_frame(); tick_frame(); idle(1);
    for (int i = 0; i < H; i++) drive(2'b11, 2, i, 2, H - 1 - i, 1'b1, 2, i);
    idle(3);

    // Random traffic on all channels.
    for (int n = 0; n < 60; n++)
      drive(2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, H - 1),
            $urandom_range(0, 7), $urandom_range(0, H - 1),
            1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, H - 1));
    idle(4);

    // Reset one cycle after a request: that read must never produce a valid.
    drive(2'b11, 1, 1, 1, 1, 1'b0, 0, 0);
    exp_q0.delete(); cyc_q0.delete();
    exp_q1.delete(); cyc_q1.delete();
    rd_en    = 2'b00;
    d1_rd_en = 1'b1; d1_tile = TW'(1); d1_row = '0;
    #1 rst = 1'b1;
    d1_rd_en = 1'b0;
    tick_cnt = 0;
    tb_phase = 1'b0;
    @(negedge clk);
    check("midrst_line", line_out, 64'd0);
    check("midrst_valid", line_valid, 64'd0);
    check("midrst_err", addr_err, 64'd0);
    check("midrst_lat1", {d1_valid, d1_err, d1_line}, 64'd0);
    #1 rst = 1'b0;
    idle(4);
    drive(2'b11, 3, 5, 1, 3, 1'b1, 3, 12);
    idle(4);

    check("drain_q0", exp_q0.size(), 0);
    check("drain_q1", exp_q1.size(), 0);
    check("drain_q2", exp_q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
